// File: rtl/apb_master_bridge_if.sv
// Command/response handshake plus APB bus bundle for apb_master_bridge.
// "master" is the bridge's view; "slave" is the view of whatever drives commands and answers APB.
interface apb_master_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [STRB_W-1:0] cmd_strb;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_slverr;
  logic              rsp_timeout;

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [STRB_W-1:0] pstrb;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    input  rsp_ready, prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
    output psel, penable, pwrite, paddr, pwdata, pstrb
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    output rsp_ready, prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
    input  psel, penable, pwrite, paddr, pwdata, pstrb
  );
endinterface

// File: rtl/apb_master_bridge.sv
// APB initiator: turns one command handshake into a SETUP/ACCESS transfer and returns
// a registered response; an optional wait-state limit aborts a stalled slave.
module apb_master_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input logic                 pclk,
  input logic                 preset_n,
  apb_master_bridge_if.master bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int CW     = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e            state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [STRB_W-1:0] pstrb_q, pstrb_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_slverr_q, rsp_slverr_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_slverr_q  <= rsp_slverr_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_slverr_d  = rsp_slverr_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;

    unique case (state_q)
      IDLE: begin
        // cmd_ready is itself a register, so acceptance follows the visible value
        if (cmd_ready_q && bus.cmd_valid) begin
          pwrite_d = bus.cmd_write;
          paddr_d  = bus.cmd_addr;
          pwdata_d = bus.cmd_wdata;
          pstrb_d  = bus.cmd_write ? bus.cmd_strb : '0;
          psel_d   = 1'b1;
          cnt_d    = '0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (bus.pready) begin
          rsp_rdata_d   = pwrite_q ? '0 : bus.prdata;
          rsp_slverr_d  = bus.pslverr;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = RESP;
        end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
          // Abort drops psel without pready; the slave never sees a completed transfer
          rsp_rdata_d   = '0;
          rsp_slverr_d  = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = RESP;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_slverr  = rsp_slverr_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.pstrb       = pstrb_q;
endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: one instance with a 16-cycle timeout, one with it disabled.
module tb_apb_master_bridge;
  localparam int TO0 = 16;

  logic pclk;
  logic preset_n;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        slverr;
    logic        timeout;
  } rsp_t;
  rsp_t exp_q[$];

  apb_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) if0 ();
  apb_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) if1 ();

  apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO0)) u_dut0 (
    .pclk(pclk), .preset_n(preset_n), .bus(if0)
  );
  apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(0)) u_dut1 (
    .pclk(pclk), .preset_n(preset_n), .bus(if1)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic outs_zero0();
    return ({if0.cmd_ready, if0.rsp_valid, if0.rsp_rdata, if0.rsp_slverr, if0.rsp_timeout,
             if0.psel, if0.penable, if0.pwrite, if0.paddr, if0.pwdata, if0.pstrb} === '0);
  endfunction

  function automatic logic outs_zero1();
    return ({if1.cmd_ready, if1.rsp_valid, if1.rsp_rdata, if1.rsp_slverr, if1.rsp_timeout,
             if1.psel, if1.penable, if1.pwrite, if1.paddr, if1.pwdata, if1.pstrb} === '0);
  endfunction

  // One full transfer on instance 0; called and returning at a falling edge.
  task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input int waits, input logic [31:0] rd,
                         input logic err, input int hold, input logic next_pending,
                         output int idle_wait);
    rsp_t        e;
    rsp_t        snap;
    logic [3:0]  exp_strb;
    int          exp_acc;
    int          acc;
    logic        ok;
    string       tag;

    tag      = $sformatf("%s@%0h", wr ? "wr" : "rd", addr);
    exp_strb = wr ? strb : 4'h0;
    if (waits >= TO0) begin
      exp_acc = TO0;
      e = '{rdata: 32'h0, slverr: 1'b1, timeout: 1'b1};
    end else begin
      exp_acc = waits + 1;
      e = '{rdata: wr ? 32'h0 : rd, slverr: err, timeout: 1'b0};
    end
    exp_q.push_back(e);

    if0.cmd_valid = 1'b1;
    if0.cmd_write = wr;
    if0.cmd_addr  = addr;
    if0.cmd_wdata = wdata;
    if0.cmd_strb  = strb;
    idle_wait = 0;
    while (!if0.cmd_ready && idle_wait < 20) begin
      @(negedge pclk);
      idle_wait++;
    end
    check({tag, " cmd_ready"}, 64'(if0.cmd_ready), 64'(1));

    @(negedge pclk);
    if0.cmd_valid = 1'b0;
    if0.pready    = 1'b0;
    if0.pslverr   = 1'b0;
    check({tag, " setup_ctl"}, 64'({if0.psel, if0.penable, if0.cmd_ready}), 64'(3'b100));
    check({tag, " setup_paddr"}, 64'(if0.paddr), 64'(addr));
    check({tag, " setup_pstrb"}, 64'({if0.pwrite, if0.pstrb}), 64'({wr, exp_strb}));

    @(negedge pclk);
    acc = 0;
    ok  = 1'b1;
    while (if0.psel === 1'b1 && acc < 200) begin
      if (!(if0.penable === 1'b1 && if0.paddr === addr && if0.pstrb === exp_strb &&
            if0.pwrite === wr && if0.pwdata === wdata && if0.cmd_ready === 1'b0)) ok = 1'b0;
      if (acc == waits) begin
        if0.pready  = 1'b1;
        if0.prdata  = rd;
        if0.pslverr = err;
      end
      @(negedge pclk);
      acc++;
      if0.pready = 1'b0;
    end
    if0.pready  = 1'bx;
    if0.pslverr = 1'bx;
    if0.prdata  = 'x;
    check({tag, " access_cycles"}, 64'(acc), 64'(exp_acc));
    check({tag, " access_stable"}, 64'(ok), 64'(1));
    check({tag, " psel_fall_rsp"}, 64'({if0.psel, if0.penable, if0.rsp_valid}), 64'(3'b001));

    snap = '{rdata: if0.rsp_rdata, slverr: if0.rsp_slverr, timeout: if0.rsp_timeout};
    ok = 1'b1;
    for (int h = 0; h < hold; h++) begin
      if0.rsp_ready = 1'b0;
      if (next_pending) begin
        if0.cmd_valid = 1'b1;
        if0.cmd_addr  = 32'hDEAD_0000;
      end
      @(negedge pclk);
      if (!(if0.rsp_valid === 1'b1 && if0.cmd_ready === 1'b0 && if0.psel === 1'b0 &&
            if0.rsp_rdata === snap.rdata && if0.rsp_slverr === snap.slverr &&
            if0.rsp_timeout === snap.timeout)) ok = 1'b0;
    end
    if (hold > 0) check({tag, " rsp_hold"}, 64'(ok), 64'(1));

    e = exp_q.pop_front();
    check({tag, " rsp_rdata"}, 64'(if0.rsp_rdata), 64'(e.rdata));
    check({tag, " rsp_flags"}, 64'({if0.rsp_slverr, if0.rsp_timeout}), 64'({e.slverr, e.timeout}));
    $display("xfer %s waits=%0d acc=%0d rdata=%h slverr=%0b timeout=%0b",
             tag, waits, acc, if0.rsp_rdata, if0.rsp_slverr, if0.rsp_timeout);

    if0.rsp_ready = 1'b1;
    @(negedge pclk);
    if0.rsp_ready = 1'b0;
    check({tag, " rsp_done"}, 64'({if0.rsp_valid, if0.cmd_ready}), 64'(2'b01));
  endtask

  initial begin
    rsp_t e1;
    int   iw;
    int   busy;

    if0.cmd_valid = 0; if0.cmd_write = 0; if0.cmd_addr = 0; if0.cmd_wdata = 0; if0.cmd_strb = 0;
    if0.rsp_ready = 0; if0.prdata = 0; if0.pready = 0; if0.pslverr = 0;
    if1.cmd_valid = 0; if1.cmd_write = 0; if1.cmd_addr = 0; if1.cmd_wdata = 0; if1.cmd_strb = 0;
    if1.rsp_ready = 0; if1.prdata = 0; if1.pready = 0; if1.pslverr = 0;
    preset_n = 1'b1;
    #1 preset_n = 1'b0;
    repeat (3) @(negedge pclk);
    check("reset_outs_u0", 64'(outs_zero0()), 64'(1));
    check("reset_outs_u1", 64'(outs_zero1()), 64'(1));
    preset_n = 1'b1;
    #1 check("cmd_ready_at_release", 64'(if0.cmd_ready), 64'(0));
    @(negedge pclk);
    check("cmd_ready_after_release", 64'({if0.cmd_ready, if1.cmd_ready}), 64'(2'b11));

    do_xfer(1'b1, 32'h0C, 32'h55, 4'hF, 0, 32'h0, 1'b0, 0, 1'b0, iw);
    do_xfer(1'b0, 32'h04, 32'h0, 4'hF, 3, 32'hA5A5_0001, 1'b0, 0, 1'b0, iw);
    do_xfer(1'b1, 32'h08, 32'h1, 4'h3, 1, 32'h0, 1'b1, 0, 1'b0, iw);
    do_xfer(1'b0, 32'h14, 32'h0, 4'h0, 1000, 32'h0, 1'b0, 0, 1'b0, iw);
    do_xfer(1'b1, 32'h18, 32'hCAFE, 4'h5, 0, 32'h0, 1'b0, 5, 1'b1, iw);
    do_xfer(1'b0, 32'h1C, 32'h0, 4'h0, 0, 32'h0BAD_F00D, 1'b0, 0, 1'b0, iw);
    check("backpressure_next_setup", 64'(iw), 64'(0));

    // Instance without a timeout must wait indefinitely on a silent slave
    if1.cmd_valid = 1'b1;
    if1.cmd_write = 1'b0;
    if1.cmd_addr  = 32'h10;
    exp_q.push_back('{rdata: 32'h1234_5678, slverr: 1'b0, timeout: 1'b0});
    @(negedge pclk);
    if1.cmd_valid = 1'b0;
    @(negedge pclk);
    busy = 0;
    for (int i = 0; i < 120; i++) begin
      if (if1.psel === 1'b1 && if1.penable === 1'b1 && if1.rsp_valid === 1'b0) busy++;
      @(negedge pclk);
    end
    check("no_timeout_wait", 64'(busy), 64'(120));
    if1.pready = 1'b1;
    if1.prdata = 32'h1234_5678;
    @(negedge pclk);
    if1.pready = 1'b0;
    e1 = exp_q.pop_front();
    check("no_timeout_rsp_valid", 64'({if1.psel, if1.rsp_valid}), 64'(2'b01));
    check("no_timeout_rdata", 64'(if1.rsp_rdata), 64'(e1.rdata));
    check("no_timeout_flags", 64'({if1.rsp_slverr, if1.rsp_timeout}), 64'({e1.slverr, e1.timeout}));
    $display("xfer u1 rd@10 long wait rdata=%h", if1.rsp_rdata);
    if1.rsp_ready = 1'b1;
    @(negedge pclk);
    if1.rsp_ready = 1'b0;

    // Reset in the middle of ACCESS
    if0.cmd_valid = 1'b1;
    if0.cmd_write = 1'b1;
    if0.cmd_addr  = 32'h20;
    if0.cmd_wdata = 32'h77;
    if0.cmd_strb  = 4'hF;
    @(negedge pclk);
    if0.cmd_valid = 1'b0;
    if0.pready    = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    check("pre_reset_access", 64'({if0.psel, if0.penable}), 64'(2'b11));
    #2 preset_n = 1'b0;
    #1 check("async_reset_outs", 64'(outs_zero0()), 64'(1));
    $display("xfer wr@20 aborted by reset");
    @(negedge pclk);
    preset_n = 1'b1;
    @(negedge pclk);
    check("reset_recover_ready", 64'(if0.cmd_ready), 64'(1));
    do_xfer(1'b0, 32'h24, 32'h0, 4'h0, 2, 32'h0000_BEEF, 1'b0, 0, 1'b0, iw);

    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
